// File: rtl/sw_ctrl.sv
// sw_ctrl: stopwatch control and timebase stage feeding the cascaded counters.
// Ports: CLK/RST (async active-high), BTN_SS/BTN_CLR/BTN_INC raw buttons in;
//        EN/CLR/INC one-cycle pulses out, STATE (00 IDLE, 01 RUN, 10 STOP),
//        HOLD display freeze (only when SW_CTRL_LAP_EN is defined).
// Latency: DEB+3 clocks from the first edge that samples a raw press to the
//          registered output pulse or STATE change. Optional macro: SW_CTRL_LAP_EN.
module sw_ctrl #(
  parameter int DIV = 500000,
  parameter int DEB = 250000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_SS,
  input  logic       BTN_CLR,
  input  logic       BTN_INC,
  output logic       EN,
  output logic       CLR,
  output logic       INC,
  output logic [1:0] STATE
`ifdef SW_CTRL_LAP_EN
  ,
  output logic       HOLD
`endif
);

  localparam int PW = $clog2(DIV);
  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10
  } state_t;

  // Button index: 0 = start/stop, 1 = clear, 2 = increment.
  logic [2:0] btn_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] lvl_w;
  logic [2:0] lvl_prev_q;
  logic [2:0] press_q;

  assign btn_raw = {BTN_INC, BTN_CLR, BTN_SS};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the level only follows the synchronised input after DEB
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic [DW-1:0] cnt_q;
    logic          lvl_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (sync2_q[g] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DW'(DEB - 1)) begin
        cnt_q <= '0;
        lvl_q <= sync2_q[g];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign lvl_w[g] = lvl_q;
  end

  // Registered rising-edge detect: one press event per accepted press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lvl_prev_q <= '0;
      press_q    <= '0;
    end else begin
      lvl_prev_q <= lvl_w;
      press_q    <= lvl_w & ~lvl_prev_q;
    end
  end

  logic ev_ss;
  logic ev_clr;
  logic ev_inc;

  assign ev_ss  = press_q[0];
  assign ev_clr = press_q[1];
  assign ev_inc = press_q[2];

  state_t        state_q;
  logic [PW-1:0] pre_q;
  logic          en_q;
  logic          clr_q;
  logic          inc_q;
`ifdef SW_CTRL_LAP_EN
  logic          hold_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      inc_q   <= 1'b0;
`ifdef SW_CTRL_LAP_EN
      hold_q  <= 1'b0;
`endif
    end else begin
      en_q  <= 1'b0;
      clr_q <= 1'b0;
      inc_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pre_q <= '0;
`ifdef SW_CTRL_LAP_EN
          hold_q <= 1'b0;
`endif
          if (ev_clr) begin
            clr_q <= 1'b1;
          end else if (ev_ss) begin
            state_q <= S_RUN;
          end else if (ev_inc) begin
            inc_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (ev_ss) begin
            // Prescaler is frozen on the stop cycle, so no EN can slip out
            // here and the partial interval resumes intact.
            state_q <= S_STOP;
`ifdef SW_CTRL_LAP_EN
            hold_q  <= 1'b0;
`endif
          end else begin
            if (pre_q == PW'(DIV - 1)) begin
              pre_q <= '0;
              en_q  <= 1'b1;
            end else begin
              pre_q <= pre_q + 1'b1;
            end
`ifdef SW_CTRL_LAP_EN
            if (ev_clr) begin
              hold_q <= ~hold_q;
            end
`endif
          end
        end
        S_STOP: begin
          if (ev_clr) begin
            clr_q   <= 1'b1;
            state_q <= S_IDLE;
            pre_q   <= '0;
          end else if (ev_ss) begin
            state_q <= S_RUN;
          end else if (ev_inc) begin
            inc_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          pre_q   <= '0;
        end
      endcase
    end
  end

  assign EN    = en_q;
  assign CLR   = clr_q;
  assign INC   = inc_q;
  assign STATE = state_q;
`ifdef SW_CTRL_LAP_EN
  assign HOLD  = hold_q;
`endif

endmodule

// File: tb/tb_sw_ctrl.sv
// tb_sw_ctrl: drives raw buttons cycle by cycle, predicts output events with a
// behavioural model (stable-window debounce, run-cycle tick counting, FSM rules)
// and checks them in a separate monitor through an expected-event queue.
module tb_sw_ctrl;

  localparam int DIV  = 4;
  localparam int DEB  = 3;
  // Cycles from the last sample of a completed DEB-long stable window to the
  // edge on which the output reacts (first sample + DEB + 3).
  localparam int LAT  = 4;
  localparam int MAXC = 8192;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       BTN_SS = 1'b0;
  logic       BTN_CLR = 1'b0;
  logic       BTN_INC = 1'b0;
  logic       EN;
  logic       CLR;
  logic       INC;
  logic [1:0] STATE;
  logic       HOLD;

  always #5 CLK = ~CLK;

  sw_ctrl #(.DIV(DIV), .DEB(DEB)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .BTN_SS (BTN_SS),
    .BTN_CLR(BTN_CLR),
    .BTN_INC(BTN_INC),
    .EN     (EN),
    .CLR    (CLR),
    .INC    (INC),
    .STATE  (STATE)
`ifdef SW_CTRL_LAP_EN
    ,
    .HOLD   (HOLD)
`endif
  );

`ifndef SW_CTRL_LAP_EN
  assign HOLD = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic       en;
    logic       clr;
    logic       inc;
    logic [1:0] st;
    logic       hold;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  bit   started = 1'b0;
  int   cyc = 0;

  logic [2:0] hist  [0:MAXC-1];
  logic [2:0] ev_at [0:MAXC+LAT+3];
  logic [2:0] raw_v = 3'b000;

  int         k = 0;
  int         m_state = 0;
  int         m_elapsed = 0;
  logic       m_hold = 1'b0;
  logic [2:0] m_lvl = 3'b000;
  bit         m_en_last = 1'b0;

  always @(posedge CLK) if (started) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_raw(logic [2:0] m);
    raw_v   = m;
    BTN_SS  = raw_v[0];
    BTN_CLR = raw_v[1];
    BTN_INC = raw_v[2];
  endtask

  // A button level is accepted once the last DEB samples all disagree with
  // the currently accepted level; only acceptances of "pressed" make events.
  task automatic model_sample(int c);
    bit all;
    for (int b = 0; b < 3; b++) begin
      if (c >= DEB - 1) begin
        all = 1'b1;
        for (int i = 0; i < DEB; i++)
          if (hist[c-i][b] == m_lvl[b]) all = 1'b0;
        if (all) begin
          m_lvl[b] = ~m_lvl[b];
          if (m_lvl[b]) ev_at[c+LAT][b] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_step(int c);
    logic [2:0] ev;
    logic       en, clr, inc, prev_hold;
    int         prev_state;
    exp_t       e;
    ev = ev_at[c];
    en = 1'b0; clr = 1'b0; inc = 1'b0;
    prev_state = m_state;
    prev_hold  = m_hold;
    case (m_state)
      0: begin
        if (ev[1]) clr = 1'b1;
        else if (ev[0]) m_state = 1;
        else if (ev[2]) inc = 1'b1;
      end
      1: begin
        if (ev[0]) begin
          m_state = 2;
          m_hold  = 1'b0;
        end else begin
          m_elapsed++;
          if (m_elapsed == DIV) begin
            en = 1'b1;
            m_elapsed = 0;
          end
`ifdef SW_CTRL_LAP_EN
          if (ev[1]) m_hold = ~m_hold;
`endif
        end
      end
      default: begin
        if (ev[1]) begin
          clr = 1'b1;
          m_state = 0;
          m_elapsed = 0;
        end else if (ev[0]) m_state = 1;
        else if (ev[2]) inc = 1'b1;
      end
    endcase
    m_en_last = en;
    if (en || clr || inc || (m_state != prev_state) || (m_hold != prev_hold)) begin
      e.cyc  = c;
      e.en   = en;
      e.clr  = clr;
      e.inc  = inc;
      e.st   = 2'(m_state);
      e.hold = m_hold;
      expq.push_back(e);
    end
  endtask

  // One clock: record the level driven for edge k, predict, then advance.
  task automatic tick();
    if (k >= MAXC) begin
      $display("FAIL cycle_budget: actual %0d cycles required below %0d", k, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    hist[k] = raw_v;
    model_sample(k);
    model_step(k);
    k++;
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic press(logic [2:0] m, int hi, int lo);
    set_raw(m);
    repeat (hi) tick();
    set_raw(3'b000);
    repeat (lo) tick();
  endtask

  // Monitor: whenever the DUT shows an event, pop and compare the prediction.
  exp_t       mon_e;
  int         mon_k;
  logic [1:0] mon_pst = 2'b00;
  logic       mon_phold = 1'b0;

  always @(negedge CLK) begin
    if (started && cyc > 0) begin
      mon_k = cyc - 1;
      while (expq.size() > 0 && expq[0].cyc < mon_k) begin
        mon_e = expq.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_event: actual none at cycle %0d, required en=%0b clr=%0b inc=%0b state=%0d hold=%0b at cycle %0d",
                 mon_k, mon_e.en, mon_e.clr, mon_e.inc, mon_e.st, mon_e.hold, mon_e.cyc);
      end
      if (EN || CLR || INC || (STATE != mon_pst) || (HOLD != mon_phold)) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: actual en=%0b clr=%0b inc=%0b state=%0d hold=%0b at cycle %0d, required no event",
                   EN, CLR, INC, STATE, HOLD, mon_k);
        end else begin
          mon_e = expq.pop_front();
          check("event_cycle", mon_k, mon_e.cyc);
          check("en",    int'(EN),    int'(mon_e.en));
          check("clr",   int'(CLR),   int'(mon_e.clr));
          check("inc",   int'(INC),   int'(mon_e.inc));
          check("state", int'(STATE), int'(mon_e.st));
          check("hold",  int'(HOLD),  int'(mon_e.hold));
        end
      end
      mon_pst   = STATE;
      mon_phold = HOLD;
    end
  end

  initial begin : stim
    int dur [3];
    bit found;
    for (int i = 0; i < MAXC; i++) hist[i] = 3'b000;
    for (int i = 0; i < MAXC + LAT + 4; i++) ev_at[i] = 3'b000;

    #2 RST = 1'b1;
    set_raw(3'b001);              // start/stop held through reset
    repeat (3) @(negedge CLK);
    check("reset_state", int'(STATE), 0);
    check("reset_en",    int'(EN),    0);
    check("reset_clr",   int'(CLR),   0);
    check("reset_inc",   int'(INC),   0);
    check("reset_hold",  int'(HOLD),  0);
    #1;
    RST = 1'b0;
    started = 1'b1;

    // Press held from reset: RUN after DEB+3, then periodic EN.
    repeat (10) tick();
    set_raw(3'b000);
    repeat (20) tick();

    press(3'b001, 5, 10);         // RUN -> STOP
    press(3'b010, 5, 10);         // STOP -> IDLE with CLR pulse

    // Short glitch, then a bouncing press.
    press(3'b001, 2, 10);
    press(3'b001, 2, 1);
    press(3'b001, 10, 20);

    // Stop exactly when the prescaler sits at 2, then resume.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_en_last) found = 1'b1;
    end
    check("en_seen_before_stop", int'(found), 1);
    press(3'b001, 5, 10);
    press(3'b001, 5, 20);

    press(3'b001, 5, 10);         // RUN -> STOP
    press(3'b011, 5, 15);         // CLR and SS together in STOP

    repeat (3) press(3'b100, 5, 6);   // INC pulses in IDLE
    press(3'b001, 5, 10);         // IDLE -> RUN
    press(3'b100, 5, 10);         // ignored in RUN
    press(3'b010, 5, 10);         // lap toggle (or ignored)
    press(3'b010, 5, 10);
    press(3'b010, 5, 10);
    press(3'b001, 5, 10);         // RUN -> STOP
    press(3'b010, 5, 10);         // STOP -> IDLE

    // Randomised raw levels with random durations around the window.
    for (int b = 0; b < 3; b++) dur[b] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (dur[b] == 0) begin
          raw_v[b] = ~raw_v[b];
          dur[b] = int'($urandom_range(1, DEB + 6));
        end
        dur[b]--;
      end
      set_raw(raw_v);
      tick();
    end

    set_raw(3'b000);
    repeat (30) tick();
    @(negedge CLK);
    #1;
    check("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
